// File: rtl/fp32_accum_seq.sv
// fp32_accum_seq: streaming FP32 reduction sequencer.
// Collects a packet of FP32 operands over a valid/ready input, feeds
// non-trivial pairs to an external fixed-latency pipelined adder and
// presents the packet sum with its element count on a valid/ready output.
// All state advances on the falling edge of clk_n, in step with the adder.
//
// Optional build macro: FP32_ACCUM_OVF_EN enables the sticky per-packet
// exponent-all-ones detector on out_ovf; without it out_ovf is tied low.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | accepting operands; zero operands are folded without the adder
// WAIT  | add issued, timing out the adder latency before capture
// OUT   | sum presented, holding until out_ready
module fp32_accum_seq #(
    parameter int ADD_LATENCY = 6,
    parameter int CNT_W       = 16
) (
    input  logic             clk_n,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    input  logic [31:0]      add_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    localparam int WCNT_W = (ADD_LATENCY < 1) ? 1 : $clog2(ADD_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_OUT
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [31:0]       acc;
    logic              acc_empty;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_inc;
    logic [WCNT_W-1:0] wcnt;
    logic              pend_last;

    logic xfer;
    logic in_zero;
    logic acc_zero;
    logic issue;
    logic capture;

    // The adder forces the hidden bit, so a +/-0 on either side must be
    // resolved here instead of being sent down the pipe.
    assign xfer      = in_valid && in_ready;
    assign in_zero   = (in_data[30:0] == 31'd0);
    assign acc_zero  = (acc[30:0] == 31'd0);
    assign issue     = xfer && !acc_empty && !in_zero && !acc_zero;
    assign capture   = (state == S_WAIT) && (wcnt == '0);
    assign count_inc = (count == CNT_MAX) ? count : count + 1'b1;

    assign in_ready  = (state == S_IDLE) && rst_n;
    assign out_valid = (state == S_OUT);
    assign out_data  = acc;
    assign out_count = count;

    // State register.
    always_ff @(negedge clk_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (issue)                state_nx = S_WAIT;
                else if (xfer && in_last) state_nx = S_OUT;
            end
            S_WAIT: begin
                if (wcnt == '0) state_nx = pend_last ? S_OUT : S_IDLE;
            end
            S_OUT: begin
                if (out_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Accumulator, element counter, adder operands and latency timer.
    always_ff @(negedge clk_n) begin
        if (!rst_n) begin
            acc       <= 32'd0;
            acc_empty <= 1'b1;
            count     <= '0;
            add_a     <= 32'd0;
            add_b     <= 32'd0;
            wcnt      <= '0;
            pend_last <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (xfer) begin
                        if (acc_empty) begin
                            acc       <= in_data;
                            acc_empty <= 1'b0;
                            count     <= CNT_W'(1);
                        end else if (in_zero) begin
                            count <= count_inc;
                        end else if (acc_zero) begin
                            acc   <= in_data;
                            count <= count_inc;
                        end else begin
                            add_a     <= acc;
                            add_b     <= in_data;
                            wcnt      <= WCNT_W'(ADD_LATENCY);
                            pend_last <= in_last;
                        end
                    end
                end
                S_WAIT: begin
                    if (wcnt == '0) begin
                        acc   <= add_result;
                        count <= count_inc;
                    end else begin
                        wcnt <= wcnt - 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        acc       <= 32'd0;
                        acc_empty <= 1'b1;
                        count     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FP32_ACCUM_OVF_EN
    logic ovf;

    // Sticky flag: any accepted operand or captured sum with exponent 8'hFF.
    always_ff @(negedge clk_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if ((state == S_OUT) && out_ready) begin
            ovf <= 1'b0;
        end else if ((xfer && (in_data[30:23] == 8'hFF)) ||
                     (capture && (add_result[30:23] == 8'hFF))) begin
            ovf <= 1'b1;
        end
    end

    assign out_ovf = ovf;
`else
    assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_fp32_accum_seq.sv
// Testbench for fp32_accum_seq: behavioural fixed-latency FP adder,
// packet-level reference model and a scoreboard monitor on the output.
module tb_fp32_accum_seq;

    localparam int LAT = 6;
    localparam int CW  = 3;

`ifdef FP32_ACCUM_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic          clk_n = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_data = 32'd0;
    logic          in_last = 1'b0;
    logic [31:0]   add_a;
    logic [31:0]   add_b;
    logic [31:0]   add_result;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_data;
    logic [CW-1:0] out_count;
    logic          out_ovf;

    fp32_accum_seq #(.ADD_LATENCY(LAT), .CNT_W(CW)) dut (
        .clk_n(clk_n), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .add_a(add_a), .add_b(add_b), .add_result(add_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .out_ovf(out_ovf)
    );

    always #5 clk_n = ~clk_n;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic [31:0] count;
        logic        ovf;
        int          adds;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // FP32 <-> real for values without denormals; overflow saturates to inf.
    function automatic real dec(input logic [31:0] f);
        logic [63:0] d;
        int e;
        if (f[30:0] == 31'd0) return 0.0;
        e = int'(f[30:23]) - 127 + 1023;
        d = {f[31], e[10:0], f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] enc(input real r);
        logic [63:0] d;
        int e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // External adder stand-in: LAT-deep pipeline sampling operands each falling edge.
    logic [31:0] pipe [LAT];
    always @(negedge clk_n) begin
        pipe[0] <= enc(dec(add_a) + dec(add_b));
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign add_result = pipe[LAT-1];

    function automatic exp_t mk(input logic [31:0] d, input int c, input bit o, input int a);
        exp_t e;
        e.data = d; e.count = 32'(c); e.ovf = o; e.adds = a;
        return e;
    endfunction

    // Packet-level reference: exact real sum, zeros never reach the adder.
    function automatic exp_t model(input logic [31:0] ops[$]);
        exp_t e;
        real s = 0.0;
        real v;
        bit allz = 1'b1;
        bit ovf = 1'b0;
        int adds = 0;
        int n = ops.size();
        logic [31:0] op;
        for (int i = 0; i < n; i++) begin
            op = ops[i];
            v = dec(op);
            if (op[30:23] == 8'hFF) ovf = 1'b1;
            if (i > 0 && v != 0.0 && s != 0.0) adds++;
            if (v != 0.0) allz = 1'b0;
            s = s + v;
        end
        if (n == 1 || allz) e.data = ops[0];
        else                e.data = enc(s);
        e.count = (n > (2**CW - 1)) ? 32'(2**CW - 1) : 32'(n);
        e.ovf   = OVF_EN && (ovf || (e.data[30:23] == 8'hFF));
        e.adds  = adds;
        return e;
    endfunction

    function automatic logic [31:0] rnd_op();
        int k;
        if ($urandom_range(0, 4) == 0) return ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h0;
        k = int'($urandom_range(1, 16));
        if ($urandom_range(0, 1) != 0) k = -k;
        return enc(real'(k) / 2.0);
    endfunction

    // out_ready policy: 0 random, 1 held low, 2 held high.
    int rmode = 2;
    initial begin
        forever begin
            @(posedge clk_n); #1;
            case (rmode)
                0:       out_ready = ($urandom_range(0, 3) != 0);
                1:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: samples mid-cycle, ahead of the falling edge that acts on it.
    bit   prev_ir = 1'b0;
    bit   in_wait = 1'b0;
    bit   chk_idle = 1'b0;
    int   low_cnt = 0;
    int   adds_seen = 0;
    exp_t mon_e;
    always begin
        @(posedge clk_n); #2;
        if (!rst_n) begin
            in_wait = 1'b0; adds_seen = 0; chk_idle = 1'b0; prev_ir = 1'b0;
        end else begin
            if (chk_idle) begin
                chk("idle_after_out", {30'd0, in_ready, out_valid}, 32'd2);
                chk_idle = 1'b0;
            end
            if (prev_ir && !in_ready && !out_valid) begin
                in_wait = 1'b1; low_cnt = 0; adds_seen++;
                chk("add_operands_nonzero", {30'd0, add_a[30:0] != 31'd0, add_b[30:0] != 31'd0}, 32'd3);
            end
            if (in_wait) begin
                if (!in_ready && !out_valid) low_cnt++;
                else begin
                    in_wait = 1'b0;
                    chk("wait_edges", low_cnt, LAT + 1);
                end
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_output: got %h expected none", out_data);
                end else begin
                    mon_e = sb.pop_front();
                    chk("out_data", out_data, mon_e.data);
                    chk("out_count", 32'(out_count), mon_e.count);
                    chk("out_ovf", {31'd0, out_ovf}, {31'd0, mon_e.ovf});
                    chk("adds_issued", adds_seen, mon_e.adds);
                end
                adds_seen = 0;
                chk_idle = 1'b1;
            end
            prev_ir = in_ready;
        end
    end

    // Called and returns at posedge+1.
    task automatic send(input logic [31:0] d, input bit last);
        int n = 0;
        in_valid = 1'b1; in_data = d; in_last = last;
        #1;
        while (!in_ready && n < 2000) begin
            @(posedge clk_n); #2;
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: got in_ready=0 expected 1");
        end
        @(posedge clk_n); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_ops(input logic [31:0] ops[$], input bit gaps);
        int g;
        for (int i = 0; i < ops.size(); i++) begin
            send(ops[i], i == ops.size() - 1);
            if (gaps) begin
                g = int'($urandom_range(0, 2));
                repeat (g) begin @(posedge clk_n); #1; end
            end
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (!(sb.size() == 0 && !out_valid) && n < 3000) begin
            @(posedge clk_n); #1;
            n++;
        end
        if (n >= 3000) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_add_a"}, add_a, 32'd0);
        chk({tag, "_add_b"}, add_b, 32'd0);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_out_data"}, out_data, 32'd0);
        chk({tag, "_out_count"}, 32'(out_count), 32'd0);
        chk({tag, "_out_ovf"}, {31'd0, out_ovf}, 32'd0);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    logic [31:0] ops[$];
    logic [31:0] hold_data;
    logic [CW-1:0] hold_cnt;
    int n;

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk_n);
        #2;
        chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk_n); #1;
        rst_n = 1'b1;
        #1;
        chk_reset_vals("reset");
        @(posedge clk_n); #1;

        // single operand, adder untouched
        sb.push_back(mk(32'h4040_0000, 1, 1'b0, 0));
        ops = '{32'h4040_0000};
        send_ops(ops, 1'b0);
        wait_drain();
        chk("single_add_a_idle", add_a, 32'd0);
        chk("single_add_b_idle", add_b, 32'd0);

        // one real add
        sb.push_back(mk(32'h4040_0000, 2, 1'b0, 1));
        send(32'h3F80_0000, 1'b0);
        send(32'h4000_0000, 1'b1);
        #1;
        chk("issue_add_a", add_a, 32'h3F80_0000);
        chk("issue_add_b", add_b, 32'h4000_0000);
        @(posedge clk_n); #1;
        wait_drain();

        // zeros folded locally
        sb.push_back(mk(32'h3FC0_0000, 3, 1'b0, 0));
        ops = '{32'h0, 32'h3FC0_0000, 32'h8000_0000};
        send_ops(ops, 1'b0);
        wait_drain();

        // two adds, then output backpressure
        rmode = 1;
        sb.push_back(mk(32'h4000_0000, 3, 1'b0, 2));
        ops = '{32'h3F80_0000, 32'h3F00_0000, 32'h3F00_0000};
        send_ops(ops, 1'b0);
        n = 0;
        while (!out_valid && n < 200) begin @(posedge clk_n); #1; n++; end
        chk("hold_reached_out", {31'd0, out_valid}, 32'd1);
        hold_data = out_data; hold_cnt = out_count;
        repeat (5) begin
            @(posedge clk_n); #1;
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_data", out_data, hold_data);
            chk("hold_count", 32'(out_count), 32'(hold_cnt));
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        rmode = 2;
        wait_drain();

        // reset while waiting on the adder
        send(32'h3F80_0000, 1'b0);
        send(32'h3F80_0000, 1'b0);
        @(posedge clk_n); #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk_n); #1;
        rst_n = 1'b1;
        #1;
        chk_reset_vals("midreset");
        @(posedge clk_n); #1;
        sb.push_back(mk(32'h4000_0000, 1, 1'b0, 0));
        ops = '{32'h4000_0000};
        send_ops(ops, 1'b0);
        wait_drain();

        // exponent overflow, then clean packet
        sb.push_back(mk(32'h7F80_0000, 2, OVF_EN, 1));
        ops = '{32'h7F00_0000, 32'h7F00_0000};
        send_ops(ops, 1'b0);
        wait_drain();
        sb.push_back(mk(32'h3F80_0000, 1, 1'b0, 0));
        ops = '{32'h3F80_0000};
        send_ops(ops, 1'b0);
        wait_drain();

        // count saturation
        sb.push_back(mk(32'h4110_0000, 2**CW - 1, 1'b0, 8));
        ops = {};
        repeat (9) ops.push_back(32'h3F80_0000);
        send_ops(ops, 1'b0);
        wait_drain();

        // randomized packets with random backpressure and gaps
        rmode = 0;
        for (int p = 0; p < 60; p++) begin
            ops = {};
            n = int'($urandom_range(1, 10));
            for (int i = 0; i < n; i++) ops.push_back(rnd_op());
            sb.push_back(model(ops));
            send_ops(ops, 1'b1);
        end
        rmode = 2;
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
